// File: rtl/dram_ctrl.sv
// dram_ctrl: requester-side controller for a 4x72 DRAM word store.
// Takes read/write requests on a valid/ready port and drives the DRAM
// address/dataIN/Write_ReadCOMP strobe. Writes are posted. Reads wait a fixed
// latency and return data on a valid/ready response port.
// Optional feature macro: PARITY_EN. When defined, user data is 64 bits and
// each byte is stored with an even-parity bit in the 72-bit word. Read data is
// checked and returned uncorrected, with rsp_err flagged.
module dram_ctrl #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 72,
  parameter int RD_LAT = 1
`ifdef PARITY_EN
  , localparam int UW = 64
`else
  , localparam int UW = DATA_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [UW-1:0]     req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [UW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIN,
  output logic              mem_Write_ReadCOMP,
  input  logic [DATA_W-1:0] mem_dataOUT
);

  // Counter must hold RD_LAT. mem_address is registered at accept, so the
  // DRAM only sees the address one edge later. The wait is therefore RD_LAT
  // edges, and the data capture happens on the edge after that.
  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } ctrlStateT;

  ctrlStateT        state;
  ctrlStateT        stateNext;
  logic [CNT_W-1:0] rdCnt;
  logic             acceptReq;
  logic             rdDone;

  // Word written to the DRAM, and data/error derived from the DRAM word
  logic [DATA_W-1:0] wrWord;
  logic [UW-1:0]     rdData;
  logic              rdErr;

`ifdef PARITY_EN
  logic [7:0] laneErr;

  // Byte lane gi sits in bits [9gi+7:9gi] with its even-parity bit at 9gi+8
  for (genvar gi = 0; gi < 8; gi++) begin : gLane
    assign wrWord[9*gi +: 8] = req_wdata[8*gi +: 8];
    assign wrWord[9*gi + 8]  = ^req_wdata[8*gi +: 8];
    assign rdData[8*gi +: 8] = mem_dataOUT[9*gi +: 8];
    assign laneErr[gi]       = ^mem_dataOUT[9*gi +: 9];
  end

  assign rdErr = |laneErr;
`else
  assign wrWord = DATA_W'(req_wdata);
  assign rdData = mem_dataOUT;
  assign rdErr  = 1'b0;
`endif

  assign acceptReq = (state == IDLE) && req_valid && req_ready;
  assign rdDone    = (state == RD) && (rdCnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (acceptReq) begin
          stateNext = req_we ? WR : RD;
        end
      end
      WR: begin
        stateNext = IDLE;
      end
      RD: begin
        if (rdDone) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Registered status flags and strobe, decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready          <= 1'b1;
      busy               <= 1'b0;
      rsp_valid          <= 1'b0;
      mem_Write_ReadCOMP <= 1'b0;
    end else begin
      req_ready          <= (stateNext == IDLE);
      busy               <= (stateNext != IDLE);
      rsp_valid          <= (stateNext == RESP);
      mem_Write_ReadCOMP <= (stateNext == WR);
    end
  end

  // Latch address/data on accept. Address and data are held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address <= '0;
      mem_dataIN  <= '0;
    end else if (acceptReq) begin
      mem_address <= req_addr;
      if (req_we) begin
        mem_dataIN <= wrWord;
      end
    end
  end

  // Read latency counter: loaded on accept, counts down while in RD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdCnt <= '0;
    end else if (acceptReq && !req_we) begin
      rdCnt <= CNT_W'(RD_LAT);
    end else if ((state == RD) && (rdCnt != '0)) begin
      rdCnt <= rdCnt - CNT_W'(1);
    end
  end

  // Capture response data. It is held stable through the RESP stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (rdDone) begin
      rsp_rdata <= rdData;
      rsp_err   <= rdErr;
    end
  end

endmodule
